// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and state encoding for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 17;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 17'h00000;
    localparam logic [4:0]         HALT_OPC  = 5'h1F;

    // Opcode field position inside an instruction word
    localparam int OPC_HI = 16;
    localparam int OPC_LO = 12;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: PC, IF/ID register, stall/flush/HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   ADDR_W    = fetch_pkg::ADDR_W,
    parameter int                   INSTR_W   = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = fetch_pkg::NOP_INSTR,
    parameter logic [4:0]           HALT_OPC  = fetch_pkg::HALT_OPC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  dst_pc,
    input  logic [INSTR_W-1:0] im_instr,
    output logic [ADDR_W-1:0]  im_addr,
    output logic               im_rd_en,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [ADDR_W-1:0]  pc_ID,
    output logic               valid_ID,
    output logic               halted,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        flush_cnt
);

    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [ADDR_W-1:0]  pc_id_q,    pc_id_d;
    logic [INSTR_W-1:0] instr_id_q, instr_id_d;
    logic               valid_id_q, valid_id_d;
    fetch_state_t       state_q,    state_d;

    logic               fetch_inc;
    logic               flush_inc;
    logic [ADDR_W-1:0]  pc_inc;
    logic               is_halt;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign is_halt = (im_instr[OPC_HI:OPC_LO] == HALT_OPC);

    always_comb begin
        pc_d       = pc_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        state_d    = state_q;
        fetch_inc  = 1'b0;
        flush_inc  = 1'b0;

        // A redirect wins over a simultaneous stall and revives a halted core
        if (flush) begin
            pc_d       = dst_pc;
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            state_d    = RUN;
            flush_inc  = 1'b1;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    instr_id_d = im_instr;
                    pc_id_d    = pc_inc;
                    valid_id_d = 1'b1;
                    fetch_inc  = 1'b1;
                    if (is_halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                HALTED: begin
                    valid_id_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_id_q    <= '0;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            valid_id_q <= valid_id_d;
            state_q    <= state_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fetch_inc),
        .cnt (fetch_cnt)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign im_addr  = pc_q;
    assign im_rd_en = !rst && !stall && (state_q == RUN);
    assign instr_ID = instr_id_q;
    assign pc_ID    = pc_id_q;
    assign valid_ID = valid_id_q;
    assign halted   = (state_q == HALTED);

endmodule
`default_nettype wire
